// File: rtl/block_nest_checker.sv
// block_nest_checker: streaming ASCII checker for begin/end and case/endcase nesting.
// One byte is consumed per cycle with in_valid=1. Words are runs of non-space bytes
// (space = 8'h20). Keywords are matched incrementally; an opener pushes its type onto a
// typed stack and a closer must pop a matching type. The partial word is evaluated as if
// already terminated, so outputs reflect the stream through the last accepted byte.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   clear     synchronous soft clear (same effect as reset, beats in_valid)
//   in_valid  consume the byte on in this cycle
//   in        ASCII byte
//   result    1 = stream so far balanced and error-free
//   error     mismatch, underflow or overflow seen (including pending word)
//   depth     effective nesting depth
//   overflow  an opener arrived at depth MAX_DEPTH
module block_nest_checker #(
    parameter int unsigned MAX_DEPTH        = 16,
    parameter int unsigned DEPTH_W          = 5,
    parameter bit          CASE_INSENSITIVE = 1'b1,
    parameter bit          ENABLE_CASE      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               result,
    output logic               error,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow
);

    // Keyword indices into the flag vector.
    localparam int KwBegin   = 0;
    localparam int KwEnd     = 1;
    localparam int KwCase    = 2;
    localparam int KwEndcase = 3;

    function automatic int kw_len(input int k);
        case (k)
            KwBegin: return 5;
            KwEnd:   return 3;
            KwCase:  return 4;
            default: return 7;
        endcase
    endfunction

    // Character i of keyword k; strings are right-aligned so char 0 is the top byte.
    function automatic logic [7:0] kw_char(input int k, input int i);
        logic [55:0] s;
        int          l;
        case (k)
            KwBegin: s = {16'h0, "begin"};
            KwEnd:   s = {32'h0, "end"};
            KwCase:  s = {24'h0, "case"};
            default: s = "endcase";
        endcase
        l = kw_len(k);
        if (i >= l) return 8'h00;
        return s[8*(l-1-i) +: 8];
    endfunction

    logic [MAX_DEPTH-1:0] stack_q, stack_d;
    logic [DEPTH_W-1:0]   sp_q, sp_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic [3:0]           pos_q, pos_d;
    logic [3:0]           flags_q, flags_d;

    logic [7:0] folded;
    logic [3:0] match;
    logic       is_open, open_type, is_close, close_type;
    logic       top_type, open_fail, close_fail, open_ok, close_ok;

    // Pending effect of the partial word, evaluated against the current stack.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            match[k] = flags_q[k] && (pos_q == 4'(kw_len(k)));
        end
        is_open    = match[KwBegin] | (ENABLE_CASE & match[KwCase]);
        open_type  = ENABLE_CASE & match[KwCase];
        is_close   = match[KwEnd] | (ENABLE_CASE & match[KwEndcase]);
        close_type = ENABLE_CASE & match[KwEndcase];

        top_type = 1'b0;
        for (int i = 0; i < int'(MAX_DEPTH); i++) begin
            if (i + 1 == int'(sp_q)) top_type = stack_q[i];
        end

        open_fail  = is_open && (sp_q == DEPTH_W'(MAX_DEPTH));
        close_fail = is_close && ((sp_q == '0) || (top_type != close_type));
        open_ok    = is_open && !open_fail;
        close_ok   = is_close && !close_fail;
    end

    assign depth    = sp_q + DEPTH_W'(open_ok) - DEPTH_W'(close_ok);
    assign error    = err_q | open_fail | close_fail;
    assign overflow = ovf_q | open_fail;
    assign result   = !error && (depth == '0);

    always_comb begin
        stack_d = stack_q;
        sp_d    = sp_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        pos_d   = pos_q;
        flags_d = flags_q;
        folded  = in;
        if (CASE_INSENSITIVE && (in >= 8'h41) && (in <= 8'h5a)) folded = in + 8'h20;

        if (clear) begin
            stack_d = '0;
            sp_d    = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            pos_d   = '0;
            flags_d = '1;
        end else if (in_valid) begin
            if (in == 8'h20) begin
                // Commit the word; a set err freezes the stack.
                if (!err_q) begin
                    if (open_fail) begin
                        err_d = 1'b1;
                        ovf_d = 1'b1;
                    end else if (is_open) begin
                        for (int i = 0; i < int'(MAX_DEPTH); i++) begin
                            if (i == int'(sp_q)) stack_d[i] = open_type;
                        end
                        sp_d = sp_q + DEPTH_W'(1);
                    end
                    if (close_fail) begin
                        err_d = 1'b1;
                    end else if (is_close) begin
                        sp_d = sp_q - DEPTH_W'(1);
                    end
                end
                pos_d   = '0;
                flags_d = '1;
            end else begin
                // pos < len also kills every flag once a word passes 7 bytes.
                for (int k = 0; k < 4; k++) begin
                    flags_d[k] = flags_q[k] && (int'(pos_q) < kw_len(k)) &&
                                 (folded == kw_char(k, int'(pos_q)));
                end
                if (pos_q != 4'd8) pos_d = pos_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stack_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            pos_q   <= '0;
            flags_q <= '1;
        end else begin
            stack_q <= stack_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            pos_q   <= pos_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: four parameterisations share one input stream and are
// compared every cycle against a word/stack model, plus hand-computed directed checks.
module tb_block_nest_checker;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid;
    logic [7:0] in_byte;

    logic       res_w [4];
    logic       err_w [4];
    logic       ovf_w [4];
    logic [4:0] dep0, dep2, dep3;
    logic [1:0] dep1;

    always #5 clk = ~clk;

    block_nest_checker u_dut0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in_byte),
        .result(res_w[0]), .error(err_w[0]), .depth(dep0), .overflow(ovf_w[0]));
    block_nest_checker #(.MAX_DEPTH(2), .DEPTH_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in_byte),
        .result(res_w[1]), .error(err_w[1]), .depth(dep1), .overflow(ovf_w[1]));
    block_nest_checker #(.CASE_INSENSITIVE(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in_byte),
        .result(res_w[2]), .error(err_w[2]), .depth(dep2), .overflow(ovf_w[2]));
    block_nest_checker #(.ENABLE_CASE(1'b0)) u_dut3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in(in_byte),
        .result(res_w[3]), .error(err_w[3]), .depth(dep3), .overflow(ovf_w[3]));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int dut_depth(input int c);
        case (c)
            0: return int'(dep0);
            1: return int'(dep1);
            2: return int'(dep2);
            default: return int'(dep3);
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic int cfg_maxd(input int c); return (c == 1) ? 2 : 16; endfunction
    function automatic bit cfg_ci(input int c); return c != 2; endfunction
    function automatic bit cfg_ec(input int c); return c != 3; endfunction

    bit  m_stk [4][16];
    int  m_sp  [4];
    bit  m_err [4];
    bit  m_ovf [4];
    byte w [16];
    int  wlen;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_sp[c] = 0; m_err[c] = 0; m_ovf[c] = 0;
        end
        wlen = 0;
    endfunction

    function automatic bit word_is(input int c, input string kw);
        byte ch;
        if (wlen != kw.len()) return 0;
        for (int i = 0; i < wlen; i++) begin
            ch = w[i];
            if (cfg_ci(c) && ch >= 8'h41 && ch <= 8'h5a) ch = ch + 8'h20;
            if (ch != kw[i]) return 0;
        end
        return 1;
    endfunction

    // Pending effect of the current word for config c.
    task automatic pending(input int c, output bit op, output bit op_t, output bit cl,
                           output bit cl_t, output bit of, output bit cf);
        bit ec;
        ec   = cfg_ec(c);
        op_t = ec && word_is(c, "case");
        op   = word_is(c, "begin") || op_t;
        cl_t = ec && word_is(c, "endcase");
        cl   = word_is(c, "end") || cl_t;
        of   = op && (m_sp[c] == cfg_maxd(c));
        cf   = cl && (m_sp[c] == 0 || m_stk[c][(m_sp[c] > 0) ? m_sp[c] - 1 : 0] != cl_t);
    endtask

    task automatic model_edge(input bit v, input byte b, input bit c_in);
        bit op, op_t, cl, cl_t, of, cf;
        if (c_in) begin
            model_reset();
        end else if (v) begin
            if (b == 8'h20) begin
                for (int c = 0; c < 4; c++) begin
                    pending(c, op, op_t, cl, cl_t, of, cf);
                    if (!m_err[c]) begin
                        if (of) begin
                            m_err[c] = 1; m_ovf[c] = 1;
                        end else if (op) begin
                            m_stk[c][m_sp[c]] = op_t; m_sp[c]++;
                        end
                        if (cf) m_err[c] = 1;
                        else if (cl) m_sp[c]--;
                    end
                end
                wlen = 0;
            end else begin
                if (wlen < 16) w[wlen] = b;
                if (wlen < 16) wlen++;
            end
        end
    endtask

    // Compare process: every negedge, all four configurations.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 4; c++) begin
                bit op, op_t, cl, cl_t, of, cf;
                int d;
                bit e;
                pending(c, op, op_t, cl, cl_t, of, cf);
                d = m_sp[c] + ((op && !of) ? 1 : 0) - ((cl && !cf) ? 1 : 0);
                e = m_err[c] || of || cf;
                chk($sformatf("cfg%0d depth", c), dut_depth(c), d);
                chk($sformatf("cfg%0d error", c), int'(err_w[c]), int'(e));
                chk($sformatf("cfg%0d overflow", c), int'(ovf_w[c]), int'(m_ovf[c] || of));
                chk($sformatf("cfg%0d result", c), int'(res_w[c]), int'(!e && d == 0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input byte b, input bit c_in);
        in_valid = v; in_byte = b; clear = c_in;
        @(posedge clk);
        model_edge(v, b, c_in);
        #2;
    endtask

    task automatic send(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) step(0, byte'($urandom_range(0, 255)), 0);
            step(1, s[i], 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    function automatic string pick_word();
        case ($urandom_range(0, 17))
            0, 1, 2: return "begin";
            3, 4:    return "case";
            5, 6:    return "end";
            7, 8:    return "endcase";
            9:       return "BeGiN";
            10:      return "END";
            11:      return "endx";
            12:      return "beginn";
            13:      return "endcasex";
            14:      return "end;";
            15:      return "x";
            16:      return "CASE";
            default: return "";
        endcase
    endfunction

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        model_reset();
        chk_en = 1'b1;
        #1;
        chk("reset result", int'(res_w[0]), 1);
        chk("reset error", int'(err_w[0]), 0);
        chk("reset depth", int'(dep0), 0);
        chk("reset overflow", int'(ovf_w[0]), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // "begin end "
        send("begi", 0); step(1, "n", 0);
        chk("be n depth", int'(dep0), 1);
        chk("be n result", int'(res_w[0]), 0);
        send(" en", 0); step(1, "d", 0);
        chk("be d depth", int'(dep0), 0);
        chk("be d result", int'(res_w[0]), 1);
        step(1, " ", 0);
        chk("be sp result", int'(res_w[0]), 1);

        // mismatch, sticky, clear
        step(0, 0, 1);
        send("begin case en", 0); step(1, "d", 0);
        chk("mm d error", int'(err_w[0]), 1);
        chk("mm d result", int'(res_w[0]), 0);
        send(" endcase end ", 0);
        chk("sticky error", int'(err_w[0]), 1);
        chk("sticky result", int'(res_w[0]), 0);
        step(0, 0, 1);
        chk("clear result", int'(res_w[0]), 1);
        chk("clear depth", int'(dep0), 0);

        // underflow withdrawn
        send("en", 0); step(1, "d", 0);
        chk("uf d error", int'(err_w[0]), 1);
        step(1, "x", 0);
        chk("uf x error", int'(err_w[0]), 0);
        chk("uf x result", int'(res_w[0]), 1);
        step(1, " ", 0);
        chk("uf sp error", int'(err_w[0]), 0);

        // overflow at MAX_DEPTH=2
        step(0, 0, 1);
        send("begin begin begi", 0); step(1, "n", 0);
        chk("ovf overflow", int'(ovf_w[1]), 1);
        chk("ovf error", int'(err_w[1]), 1);
        chk("ovf depth", int'(dep1), 2);
        chk("ovf result", int'(res_w[1]), 0);
        chk("ovf deep cfg0", int'(dep0), 3);

        // case folding / case keywords
        step(0, 0, 1);
        send("BEGIN ", 0);
        chk("cs BEGIN depth", int'(dep2), 0);
        chk("cs BEGIN result", int'(res_w[2]), 1);
        step(0, 0, 1);
        send("BeGiN ", 0);
        chk("ci BeGiN depth", int'(dep0), 1);
        step(0, 0, 1);
        send("case ", 0);
        chk("nocase depth", int'(dep3), 0);
        chk("case depth", int'(dep0), 1);

        // reset mid-word, then idle with in='n'
        step(0, 0, 1);
        send("begi", 0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst result", int'(res_w[0]), 1);
        chk("rst depth", int'(dep0), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step(0, "n", 0);
        chk("idle result", int'(res_w[0]), 1);
        chk("idle depth", int'(dep0), 0);

        // randomized stream
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                step(bit'($urandom_range(0, 1)), byte'($urandom_range(0, 255)), 1);
            end else begin
                send(pick_word(), 1);
                step(1, " ", 0);
                if ($urandom_range(0, 4) == 0) step(1, " ", 0);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
